// File: rtl/rst_seq_if.sv
// Handshake bundle between the reset sequencer and the domains it releases.
// The master side drives the request and acks. The slave side (the sequencer)
// drives the per-domain resets and the status outputs.
interface rst_seq_if #(
   parameter int N_STAGE = 3
);
   logic               req_in;
   logic [N_STAGE-1:0] ack;
   logic [N_STAGE-1:0] stg_rst;
   logic [3:0]         stage;
   logic               done;
   logic               err;

   modport master (
      output req_in, ack,
      input  stg_rst, stage, done, err
   );

   modport slave (
      input  req_in, ack,
      output stg_rst, stage, done, err
   );
endinterface

// File: rtl/rst_seq.sv
// Reset release sequencer. It takes the synchronized reset request and releases
// N_STAGE reset domains one at a time, stage 0 first. Each stage waits for the
// previous stage's ack plus a DLY-cycle gap. A missing ack for TMO cycles puts
// every domain back into reset and raises err.
module rst_seq #(
   parameter int N_STAGE = 3,
   parameter int DLY     = 4,
   parameter int TMO     = 8
) (
   input logic        clk,
   input logic        rst,
   rst_seq_if.slave   bus
);
   localparam int CMAX = (DLY > TMO) ? DLY : TMO;
   localparam int CW   = $clog2(CMAX) + 1;

   localparam logic [CW-1:0] DLY_LAST = CW'(DLY - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);
   localparam logic [3:0]    LAST_STG = 4'(N_STAGE - 1);

   typedef enum logic [2:0] {
      S_HOLD,
      S_WACK,
      S_GAP,
      S_DONE,
      S_ERR
   } state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt, cnt_nxt, cnt_inc;
   logic [3:0]         stage, stage_nxt;
   logic [N_STAGE-1:0] stg_rst, stg_rst_nxt;
   logic [N_STAGE-1:0] sel;
   logic               done, done_nxt;
   logic               err, err_nxt;
   logic               ack_cur;

   // The shared counter saturates instead of wrapping.
   assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

   // One-hot select of the current stage. Acks from other stages are masked off.
   assign sel     = N_STAGE'(1) << stage;
   assign ack_cur = |(bus.ack & sel);

   // Next-state and next-output logic for the release sequence.
   always_comb begin
      // NOTE: every target gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      state_nxt   = state;
      cnt_nxt     = cnt;
      stage_nxt   = stage;
      stg_rst_nxt = stg_rst;
      done_nxt    = done;
      err_nxt     = err;

      if (bus.req_in) begin
         // A new request wins over any ack or timeout seen on the same edge.
         state_nxt   = S_HOLD;
         cnt_nxt     = '0;
         stage_nxt   = '0;
         stg_rst_nxt = '1;
         done_nxt    = 1'b0;
         err_nxt     = 1'b0;
      end else begin
         unique case (state)
            S_HOLD: begin
               if (cnt == DLY_LAST) begin
                  state_nxt      = S_WACK;
                  cnt_nxt        = '0;
                  stage_nxt      = '0;
                  stg_rst_nxt[0] = 1'b0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            S_WACK: begin
               if (ack_cur) begin
                  if (stage == LAST_STG) begin
                     state_nxt = S_DONE;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt = S_GAP;
                     cnt_nxt   = '0;
                  end
               end else if (cnt == TMO_LAST) begin
                  state_nxt   = S_ERR;
                  cnt_nxt     = '0;
                  stg_rst_nxt = '1;
                  err_nxt     = 1'b1;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            S_GAP: begin
               if (cnt == DLY_LAST) begin
                  state_nxt   = S_WACK;
                  cnt_nxt     = '0;
                  stage_nxt   = stage + 4'd1;
                  stg_rst_nxt = stg_rst & ~(sel << 1);
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            S_DONE, S_ERR: begin
               // Both hold until a new request arrives.
            end
            default: state_nxt = S_HOLD;
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state   <= S_HOLD;
         cnt     <= '0;
         stage   <= '0;
         stg_rst <= '1;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         stage   <= stage_nxt;
         stg_rst <= stg_rst_nxt;
         done    <= done_nxt;
         err     <= err_nxt;
      end
   end

   assign bus.stg_rst = stg_rst;
   assign bus.stage   = stage;
   assign bus.done    = done;
   assign bus.err     = err;
endmodule
